reaction_timer_multi: RTL and testbench
=======================================

# reaction_timer_multi

Parametrised multi-round successor to the single-shot reaction timer. Runs a session of `ROUNDS` trials, each with an LFSR-randomised wait before the stimulus LED lights. It measures each reaction in milliseconds and tracks per-session average and persistent best. Sits between the debounced button front-end and the display formatter; it outputs binary millisecond values only, and BCD/7-segment conversion happens downstream.

## Interface

**Parameters**
- `CLK_HZ`, 100_000_000: clock frequency. `TICK_DIV = CLK_HZ/1000` cycles per ms tick.
- `ROUNDS`, 4: trials per session. Must be a power of two, 1..16.
- `MIN_DELAY_MS`, 2000: minimum wait before stimulus.
- `RAND_BITS`, 11: random wait span; extra delay is 0..2^RAND_BITS-1 ms.
- `MAX_MS`, 1000: reaction timeout; must be ≤ 9998.

**Ports**
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: one-cycle pulse, already debounced.
- `stop` in 1: one-cycle pulse, already debounced.
- `clear` in 1: one-cycle pulse, already debounced.
- `stim_led` out 1: stimulus LED.
- `time_ms` out 14: current or last round time. Set to 9999 on cheat.
- `best_ms` out 14: best valid round since `rst`. 9999 means none yet.
- `avg_ms` out 14: session average, valid when `done`.
- `round_idx` out 4: number of completed rounds.
- `busy` out 1: high in WAIT or REACT.
- `done` out 1: high in DONE.
- `cheat` out 1: high in CHEAT.
- `timeout` out 1: last round hit `MAX_MS`.

## Operation

**States:** IDLE, WAIT, REACT, RESULT, DONE, CHEAT.

**Transitions**
- IDLE + `start` → WAIT.
- WAIT: counts ms. On reaching the latched delay → REACT, `stim_led`=1, `time_ms`=0.
- WAIT + `stop` → CHEAT. Session aborts and the sum is discarded.
- REACT: `time_ms` increments per tick.
  - `stop` → RESULT. The round is recorded.
  - If `time_ms` reaches `MAX_MS` → RESULT with `timeout`=1 and the round recorded as `MAX_MS`.
- RESULT: `stim_led`=0, holds `time_ms`.
  - If `round_idx`==ROUNDS → DONE.
  - Otherwise `start` → WAIT.
- DONE: holds all outputs. `start` begins a new session: `round_idx`, sum and `avg_ms` are zeroed, then → WAIT.
- CHEAT: only `clear` exits.

**Recording a round**
- `round_idx`+1.
- sum += time.
- `best_ms` = min(`best_ms`, time). Timeouts and cheats never update best.

**`clear`, from any state** → IDLE. Zeroes `time_ms`, `round_idx`, sum, `avg_ms`, `cheat`, `timeout`; `stim_led`=0. `best_ms` is retained.

**Arithmetic**
- Sum width is 14+log2(ROUNDS).
- `avg_ms` = sum >> log2(ROUNDS), truncating. It is computed on entry to DONE.

**Random delay**
- 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1. It never reaches zero.
- The LFSR advances every cycle, including while idle.
- On entry to WAIT: delay = `MIN_DELAY_MS` + lfsr[RAND_BITS-1:0].

**Priority**
- `clear` > `stop` > `start`.
- `stop` in the same cycle as the WAIT→REACT transition is judged against the current state (WAIT), so it is a cheat.
- `start` is ignored in WAIT, REACT and CHEAT.

## Timing

- **Reset values:** state IDLE; all outputs 0, except `best_ms`=9999. LFSR is loaded with the seed.
- **Outputs:** all registered; they change the cycle after the causing input or tick.
- **ms prescaler:** clears on every state change. The first tick comes `TICK_DIV` cycles after entry, so the wait is exact to ±0 cycles.
- **Delay:** WAIT→REACT occurs exactly delay×`TICK_DIV` cycles after WAIT entry.
- **Count semantics:** a `stop` before the first tick in REACT records 0 ms. `time_ms` equals the number of whole ticks elapsed.
- **Timeout:** triggers on the tick that makes the count equal `MAX_MS`, which is `MAX_MS`×`TICK_DIV` cycles after REACT entry.
- **Statistics:** `best_ms`/`round_idx` update one cycle after the REACT→RESULT transition. `avg_ms` is valid in the same cycle `done` rises.
- **`rst` mid-session:** resets everything, including `best_ms`.

## Structure

- **Package `reaction_pkg`:**
  - `state_t` enum.
  - `MS_W`=14.
  - `CHEAT_CODE`=14'd9999.
  - `NO_BEST`=14'd9999.
  - `LFSR_SEED`.
- **Sub-module `ms_tick_gen`:** parameter `TICK_DIV`; inputs `clk`, `rst`, `clr`; output one-cycle `tick`.
- **Top level:** the FSM, LFSR, counters and stats live in the top level.

## Test plan

Simulation parameters: `CLK_HZ`=4000 (`TICK_DIV`=4), `MIN_DELAY_MS`=4, `RAND_BITS`=3, `MAX_MS`=20, `ROUNDS`=4.

1. **Reset:** assert `rst` → `best_ms`=9999, other outputs 0, state IDLE.
2. **Single round, exact timing:** `start`, then `stop` 7 ticks after `stim_led` rises → `time_ms`=7, `round_idx`=1, `best_ms`=7. The WAIT duration equals (4+lfsr[2:0])×4 cycles, checked against a model LFSR.
3. **Full session:** rounds 7, 12, timeout, 5 → `timeout` set in round 3, `done`=1, `avg_ms`=(7+12+20+5)>>2=11, `best_ms`=5.
4. **Cheat:** `stop` during WAIT, including the exact transition cycle → `cheat`=1, `time_ms`=9999, `stim_led`=0. `start` is ignored; `clear` → IDLE with `cheat`=0.
5. **Persistent best:** after test 3, `clear` then a new 9 ms round → `best_ms` stays 5. After `rst`, `best_ms`=9999.
6. **Priority:** `clear`+`stop` in the same cycle in REACT → IDLE with nothing recorded. `start` in REACT → no effect.

Source files
------------

// File: rtl/reaction_pkg.sv
// reaction_pkg
//   Shared types and constants for the multi-round reaction timer.
//   - state_t    : top-level FSM states
//   - MS_W       : width of every millisecond value leaving the block
//   - CHEAT_CODE : value shown on time_ms after a premature stop
//   - NO_BEST    : best_ms value meaning "no valid round yet"
//   - LFSR_SEED  : non-zero seed for the random-delay LFSR
//   - lfsr_next  : one step of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
package reaction_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REACT,
    S_RESULT,
    S_DONE,
    S_CHEAT
  } state_t;

  localparam int              MS_W       = 14;
  localparam logic [MS_W-1:0] CHEAT_CODE = 14'd9999;
  localparam logic [MS_W-1:0] NO_BEST    = 14'd9999;
  localparam logic [15:0]     LFSR_SEED  = 16'hACE1;

  // Taps 16,14,13,11 map to bit indices 15,13,12,10. A non-zero state
  // never reaches zero with this maximal-length polynomial.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen
//   Millisecond prescaler. Counts clock cycles and raises tick for one
//   cycle every TICK_DIV cycles. While clr is high the count is held at
//   zero, so the first tick after clr drops arrives exactly TICK_DIV
//   cycles after the last clr cycle.
//   Ports:
//     clk  in  : clock
//     rst  in  : synchronous active-high reset
//     clr  in  : hold prescaler at zero
//     tick out : one-cycle pulse per millisecond
module ms_tick_gen #(
  parameter int TICK_DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign tick   = w_last && !clr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reaction_timer_multi.sv
// reaction_timer_multi
//   Multi-round reaction timer. A session is ROUNDS trials; each trial
//   waits MIN_DELAY_MS plus an LFSR-chosen 0..2^RAND_BITS-1 ms, lights the
//   stimulus LED and measures the reaction in ms. Tracks session sum and
//   average plus the best valid round since reset.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     start, stop, clear: one-cycle debounced button pulses
//     stim_led          : stimulus LED
//     time_ms           : current/last round time (9999 after a cheat)
//     best_ms           : best valid round since reset (9999 = none)
//     avg_ms            : session average, valid while done
//     round_idx         : completed rounds in this session
//     busy/done/cheat   : status flags (WAIT|REACT / DONE / CHEAT)
//     timeout           : last round hit MAX_MS
module reaction_timer_multi
  import reaction_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int ROUNDS       = 4,
  parameter int MIN_DELAY_MS = 2000,
  parameter int RAND_BITS    = 11,
  parameter int MAX_MS       = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            clear,
  output logic            stim_led,
  output logic [MS_W-1:0] time_ms,
  output logic [MS_W-1:0] best_ms,
  output logic [MS_W-1:0] avg_ms,
  output logic [3:0]      round_idx,
  output logic            busy,
  output logic            done,
  output logic            cheat,
  output logic            timeout
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int RND_LOG  = $clog2(ROUNDS);
  localparam int SUM_W    = MS_W + RND_LOG;
  localparam int DLY_W    = 17;
  // One extra bit so a 16-round session can still compare against ROUNDS.
  localparam int RC_W     = 5;

  state_t           r_state;
  logic [15:0]      r_lfsr;
  logic [DLY_W-1:0] r_delay;
  logic [DLY_W-1:0] r_wait_ms;
  logic [MS_W-1:0]  r_time;
  logic [MS_W-1:0]  r_best;
  logic [MS_W-1:0]  r_avg;
  logic [SUM_W-1:0] r_sum;
  logic [RC_W-1:0]  r_round;
  logic             r_rec_pend;
  logic             r_stim;
  logic             r_busy;
  logic             r_done;
  logic             r_cheat;
  logic             r_timeout;

  logic             w_tick;
  logic             w_presc_clr;
  logic [DLY_W-1:0] w_new_delay;

  // The prescaler only runs in the two timed states. Every entry into WAIT
  // comes from a non-timed state, and WAIT->REACT happens on a tick edge
  // where the prescaler wraps to zero anyway, so every state entry starts
  // a fresh millisecond.
  assign w_presc_clr = (r_state != S_WAIT) && (r_state != S_REACT);

  assign w_new_delay = DLY_W'(MIN_DELAY_MS) + DLY_W'(r_lfsr[RAND_BITS-1:0]);

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_presc_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lfsr     <= LFSR_SEED;
      r_delay    <= '0;
      r_wait_ms  <= '0;
      r_time     <= '0;
      r_best     <= NO_BEST;
      r_avg      <= '0;
      r_sum      <= '0;
      r_round    <= '0;
      r_rec_pend <= 1'b0;
      r_stim     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cheat    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);

      if (clear) begin
        r_state    <= S_IDLE;
        r_time     <= '0;
        r_round    <= '0;
        r_sum      <= '0;
        r_avg      <= '0;
        r_rec_pend <= 1'b0;
        r_stim     <= 1'b0;
        r_busy     <= 1'b0;
        r_done     <= 1'b0;
        r_cheat    <= 1'b0;
        r_timeout  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state   <= S_WAIT;
              r_busy    <= 1'b1;
              r_timeout <= 1'b0;
              r_wait_ms <= '0;
              r_delay   <= w_new_delay;
            end
          end

          S_WAIT: begin
            // stop is judged before the tick, so a stop on the very
            // cycle the LED would light is still a cheat.
            if (stop) begin
              r_state <= S_CHEAT;
              r_busy  <= 1'b0;
              r_cheat <= 1'b1;
              r_time  <= CHEAT_CODE;
              r_sum   <= '0;
            end else if (w_tick) begin
              if (r_wait_ms + DLY_W'(1) >= r_delay) begin
                r_state <= S_REACT;
                r_stim  <= 1'b1;
                r_time  <= '0;
              end else begin
                r_wait_ms <= r_wait_ms + DLY_W'(1);
              end
            end
          end

          S_REACT: begin
            if (stop) begin
              r_state    <= S_RESULT;
              r_stim     <= 1'b0;
              r_busy     <= 1'b0;
              r_rec_pend <= 1'b1;
            end else if (w_tick) begin
              if (r_time + MS_W'(1) == MS_W'(MAX_MS)) begin
                r_state    <= S_RESULT;
                r_stim     <= 1'b0;
                r_busy     <= 1'b0;
                r_timeout  <= 1'b1;
                r_time     <= MS_W'(MAX_MS);
                r_rec_pend <= 1'b1;
              end else begin
                r_time <= r_time + MS_W'(1);
              end
            end
          end

          S_RESULT: begin
            // Statistics are folded in on the first RESULT cycle; the
            // session-complete check and start are honoured afterwards.
            if (r_rec_pend) begin
              r_rec_pend <= 1'b0;
              r_round    <= r_round + RC_W'(1);
              r_sum      <= r_sum + SUM_W'(r_time);
              if (!r_timeout && (r_time < r_best)) begin
                r_best <= r_time;
              end
            end else if (r_round == RC_W'(ROUNDS)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_avg   <= MS_W'(r_sum >> RND_LOG);
            end else if (start) begin
              r_state   <= S_WAIT;
              r_busy    <= 1'b1;
              r_timeout <= 1'b0;
              r_wait_ms <= '0;
              r_delay   <= w_new_delay;
            end
          end

          S_DONE: begin
            if (start) begin
              r_state   <= S_WAIT;
              r_busy    <= 1'b1;
              r_done    <= 1'b0;
              r_timeout <= 1'b0;
              r_round   <= '0;
              r_sum     <= '0;
              r_avg     <= '0;
              r_wait_ms <= '0;
              r_delay   <= w_new_delay;
            end
          end

          S_CHEAT: begin
            // Held until clear.
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign stim_led  = r_stim;
  assign time_ms   = r_time;
  assign best_ms   = r_best;
  assign avg_ms    = r_avg;
  assign round_idx = r_round[3:0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign cheat     = r_cheat;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_reaction_timer_multi.sv
module tb_reaction_timer_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        clear;
  logic        stim_led;
  logic [13:0] time_ms;
  logic [13:0] best_ms;
  logic [13:0] avg_ms;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;
  logic        cheat;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  reaction_timer_multi #(
    .CLK_HZ       (4000),
    .ROUNDS       (4),
    .MIN_DELAY_MS (4),
    .RAND_BITS    (3),
    .MAX_MS       (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .stim_led  (stim_led),
    .time_ms   (time_ms),
    .best_ms   (best_ms),
    .avg_ms    (avg_ms),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done),
    .cheat     (cheat),
    .timeout   (timeout)
  );

  // Reference LFSR: taps 16,14,13,11, seed ACE1, steps every cycle.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  // Pulse start and wait for the LED; wait length must match the model.
  task automatic start_wait(input string tag);
    int exp_cycles;
    int n;
    exp_cycles = (4 + int'(m_lfsr[2:0])) * 4;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    n = 0;
    while (!stim_led && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_wait"}, n, exp_cycles);
  endtask

  // Called one cycle after REACT entry; stops after k whole ticks.
  task automatic react_stop(input string tag, input int k);
    repeat (4 * k + 1) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk({tag, "_time"}, time_ms, k);
    chk({tag, "_led"}, stim_led, 0);
    step();
  endtask

  initial begin
    int n;
    int exp_cycles;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    repeat (3) step();

    // 1. Reset values
    chk("rst_best", best_ms, 9999);
    chk("rst_time", time_ms, 0);
    chk("rst_avg", avg_ms, 0);
    chk("rst_round", round_idx, 0);
    chk("rst_flags", {stim_led, busy, done, cheat, timeout}, 0);
    rst = 1'b0;
    step();

    // 2. Single round of 7 ms
    start_wait("r1");
    react_stop("r1", 7);
    chk("r1_round", round_idx, 1);
    chk("r1_best", best_ms, 7);
    chk("r1_busy", busy, 0);

    // 3. Full session: 7, 12, timeout, 5
    start_wait("r2");
    react_stop("r2", 12);
    chk("r2_round", round_idx, 2);
    chk("r2_best", best_ms, 7);

    start_wait("r3");
    n = 0;
    while (stim_led && n < 200) begin
      step();
      n++;
    end
    chk("r3_to_len", n, 80);
    chk("r3_timeout", timeout, 1);
    chk("r3_time", time_ms, 20);
    step();
    chk("r3_round", round_idx, 3);
    chk("r3_best", best_ms, 7);

    start_wait("r4");
    chk("r4_to_clr", timeout, 0);
    react_stop("r4", 5);
    chk("r4_round", round_idx, 4);
    chk("r4_done_lat", done, 0);
    step();
    chk("sess_done", done, 1);
    chk("sess_avg", avg_ms, 11);
    chk("sess_best", best_ms, 5);

    // 5. Persistent best across clear
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_done", done, 0);
    chk("clr_round", round_idx, 0);
    chk("clr_avg", avg_ms, 0);
    chk("clr_best", best_ms, 5);
    start_wait("r9");
    react_stop("r9", 9);
    chk("r9_round", round_idx, 1);
    chk("r9_best", best_ms, 5);

    // 4. Cheat during WAIT
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("ch_cheat", cheat, 1);
    chk("ch_time", time_ms, 9999);
    chk("ch_led", stim_led, 0);
    chk("ch_busy", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ch_start_ign", {cheat, busy}, 2'b10);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("ch_clr_cheat", cheat, 0);
    chk("ch_clr_time", time_ms, 0);

    // Cheat on the exact WAIT->REACT cycle
    exp_cycles = (4 + int'(m_lfsr[2:0])) * 4;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (exp_cycles - 1) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("chx_cheat", cheat, 1);
    chk("chx_led", stim_led, 0);
    chk("chx_time", time_ms, 9999);
    clear = 1'b1;
    step();
    clear = 1'b0;

    // 6. clear + stop together in REACT
    start_wait("pr");
    repeat (2) step();
    clear = 1'b1;
    stop  = 1'b1;
    step();
    clear = 1'b0;
    stop  = 1'b0;
    chk("pr_state", {stim_led, busy, cheat, done}, 0);
    chk("pr_time", time_ms, 0);
    step();
    chk("pr_round", round_idx, 0);
    chk("pr_best", best_ms, 5);

    // start during REACT is ignored
    start_wait("sr");
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("sr_led", stim_led, 1);
    chk("sr_time", time_ms, 1);
    repeat (7) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("sr_stop_time", time_ms, 3);
    step();
    chk("sr_round", round_idx, 1);
    chk("sr_best", best_ms, 3);

    // rst clears best
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rst2_best", best_ms, 9999);
    chk("rst2_round", round_idx, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
